// File: rtl/uart_rx_irq_if.sv
// uart_rx_irq_if: serial input plus CPU read side (data, interrupt request, acknowledge)
interface uart_rx_irq_if;
  logic       rx;
  logic       ack;
  logic [7:0] r_data;
  logic       irr;
  modport master (output rx, output ack, input r_data, input irr);
  modport slave (input rx, input ack, output r_data, output irr);
endinterface

// File: rtl/uart_rx_irq.sv
// uart_rx_irq: 8N1 LSB-first UART receiver with sticky byte-received interrupt cleared by ack
// Define UART_RX_FRAMING_CHECK_EN to drop frames whose stop bit samples low.
module uart_rx_irq #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_irq_if.slave bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rxs, rxs_d;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, r_data_q;
  logic irr_q, load, fall, hit_half, hit_bit;
  assign fall = rxs_d & ~rxs;
  assign hit_half = cnt == CW'(HALF - 1);
  assign hit_bit = cnt == CW'(CLKS_PER_BIT - 1);
  assign bus.r_data = r_data_q;
  assign bus.irr = irr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rxs      <= 1'b1;
      rxs_d    <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      r_data_q <= '0;
      irr_q    <= 1'b0;
    end else begin
      rx_m     <= bus.rx;
      rxs      <= rx_m;
      rxs_d    <= rxs;
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      r_data_q <= load ? sh : r_data_q;
      irr_q    <= load | (irr_q & ~bus.ack);
    end
  end
  // the counter wraps on every sample point, so STOP returns to IDLE ready for the next edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    load    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) state_n = START;
      end
      START: if (hit_half) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (hit_bit) begin
        cnt_n   = '0;
        sh_n    = {rxs, sh[7:1]};
        idx_n   = idx + 3'd1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (hit_bit) begin
        cnt_n   = '0;
        state_n = IDLE;
`ifdef UART_RX_FRAMING_CHECK_EN
        load    = rxs;
`else
        load    = 1'b1;
`endif
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_irq.sv
// tb_uart_rx_irq: directed checks of the UART receiver at CLKS_PER_BIT=8
module tb_uart_rx_irq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errs = 0;
  int n;
  uart_rx_irq_if bus ();
  uart_rx_irq #(.CLKS_PER_BIT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // ack_at_load raises ack only in the stop-sample cycle (frame cycle 78 after rx falls)
  task automatic send(input logic [7:0] d, input logic stop, input logic ack_at_load);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      bus.rx = f[k];
      for (int j = 0; j < 8; j++) begin
        if (ack_at_load) bus.ack = (k == 9 && j == 6);
        tick(1);
      end
    end
    bus.rx = 1'b1;
    bus.ack = 1'b0;
  endtask
  task automatic pulse_ack();
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
  endtask
  initial begin
    bus.rx = 1'b1;
    bus.ack = 1'b0;
    tick(3);
    chk("reset_r_data", 32'(bus.r_data), 32'h00);
    chk("reset_irr", 32'(bus.irr), 32'h0);
    rst = 1'b0;
    tick(2);
    bus.rx = 1'b0;
    tick(30);
    #2 rst = 1'b1;
    bus.rx = 1'b1;
    tick(2);
    chk("midframe_reset", 32'({bus.irr, bus.r_data}), 32'h000);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      chk("idle_after_reset", 32'({bus.irr, bus.r_data}), 32'h000);
    end
    fork
      send(8'hA5, 1'b1, 1'b0);
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!bus.irr && n < 200);
      end
    join
    chk("latency", 32'(n), 32'd79);
    chk("single_r_data", 32'(bus.r_data), 32'hA5);
    chk("single_irr", 32'(bus.irr), 32'h1);
    pulse_ack();
    chk("ack_clears_irr", 32'(bus.irr), 32'h0);
    chk("ack_keeps_r_data", 32'(bus.r_data), 32'hA5);
    pulse_ack();
    chk("ack_idle_noop", 32'({bus.irr, bus.r_data}), 32'h0A5);
    bus.rx = 1'b0;
    tick(2);
    bus.rx = 1'b1;
    tick(20);
    chk("glitch_rejected", 32'({bus.irr, bus.r_data}), 32'h0A5);
    send(8'h3C, 1'b1, 1'b0);
    chk("after_glitch", 32'({bus.irr, bus.r_data}), 32'h13C);
    pulse_ack();
    chk("ack_3c", 32'(bus.irr), 32'h0);
    send(8'h00, 1'b1, 1'b0);
    chk("b2b_first", 32'({bus.irr, bus.r_data}), 32'h100);
    send(8'hFF, 1'b1, 1'b0);
    chk("b2b_overrun", 32'({bus.irr, bus.r_data}), 32'h1FF);
    send(8'h5A, 1'b1, 1'b1);
    chk("load_beats_ack", 32'({bus.irr, bus.r_data}), 32'h15A);
    pulse_ack();
    chk("ack_5a", 32'({bus.irr, bus.r_data}), 32'h05A);
    send(8'h81, 1'b0, 1'b0);
    tick(10);
`ifdef UART_RX_FRAMING_CHECK_EN
    chk("framing_error", 32'({bus.irr, bus.r_data}), 32'h05A);
`else
    chk("framing_ignored", 32'({bus.irr, bus.r_data}), 32'h181);
    pulse_ack();
`endif
    send(8'hC3, 1'b1, 1'b0);
    chk("after_framing", 32'({bus.irr, bus.r_data}), 32'h1C3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
